// File: rtl/reg_wb_pkg.sv
// Shared widths and the writeback entry type for the register-file write-port arbiter.
package reg_wb_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREG   = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] wn;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/reg_wb_fifo.sv
// Small power-of-two FIFO holding multicycle results until the write port is free.
module reg_wb_fifo
  import reg_wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  wb_entry_t                din,
  input  logic                     pop,
  output wb_entry_t                dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t          mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Arbitrates the register-file write port between pipeline writeback and buffered
// multicycle results, with a busy-bit scoreboard and starvation-forced drains.
module reg_wb_arbiter
  import reg_wb_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int STARVE = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pipe_we,
  input  logic [ADDR_W-1:0] pipe_wn,
  input  logic [DATA_W-1:0] pipe_data,
  input  logic              mc_issue,
  input  logic [ADDR_W-1:0] mc_rd,
  input  logic              mc_valid,
  input  logic [ADDR_W-1:0] mc_wn,
  input  logic [DATA_W-1:0] mc_data,
  output logic              mc_ready,
  input  logic [ADDR_W-1:0] rna,
  input  logic [ADDR_W-1:0] rnb,
  output logic              stall,
  output logic              wreg,
  output logic [ADDR_W-1:0] wn,
  output logic [DATA_W-1:0] datain
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int SW    = $clog2(STARVE + 1);

  logic [NREG-1:0]  busy;
  logic [NREG-1:0]  busy_next;
  logic [SW-1:0]    starve_cnt;
  wb_entry_t        head;
  wb_entry_t        fifo_in;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             push;
  logic             pipe_valid;
  logic             raw;
  logic             waw;
  logic             force_drain;
  logic             pipe_ok;
  logic             head_grant;

  assign fifo_in = '{wn: mc_wn, data: mc_data};

  reg_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (fifo_in),
    .pop   (head_grant),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign pipe_valid  = pipe_we && (pipe_wn != '0);
  assign raw         = ((rna != '0) && busy[rna]) || ((rnb != '0) && busy[rnb]);
  assign waw         = pipe_valid && busy[pipe_wn];
  assign force_drain = !fifo_empty && (starve_cnt == SW'(STARVE));
  assign pipe_ok     = pipe_valid && !waw && !force_drain;
  assign head_grant  = !reset && !pipe_ok && !fifo_empty;

  // Readiness is not relieved by a same-cycle dequeue, so a full FIFO always refuses.
  assign mc_ready = !reset && (fifo_count < CNT_W'(DEPTH));
  assign push     = mc_valid && mc_ready && !fifo_full && (mc_wn != '0);

  always_comb begin
    wreg   = 1'b0;
    wn     = '0;
    datain = '0;
    stall  = 1'b0;
    if (!reset) begin
      stall = raw || waw || (force_drain && pipe_valid);
      if (pipe_ok) begin
        wreg   = 1'b1;
        wn     = pipe_wn;
        datain = pipe_data;
      end else if (!fifo_empty) begin
        wreg   = 1'b1;
        wn     = head.wn;
        datain = head.data;
      end
    end
  end

  // Clear is applied before set so a same-cycle reissue keeps the register owned.
  always_comb begin
    busy_next = busy;
    if (head_grant) begin
      busy_next[head.wn] = 1'b0;
    end
    if (mc_issue && (mc_rd != '0)) begin
      busy_next[mc_rd] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || fifo_empty || head_grant) begin
      starve_cnt <= '0;
    end else if (starve_cnt != SW'(STARVE)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule
